// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter that funnels NumPorts cache clients into one memory request
// channel and routes memory returns back to the issuing client by port index.
module wt_mem_arbiter #(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned ClientIdWidth  = 2,
   parameter int unsigned ReqWidth       = 64,
   parameter int unsigned RtrnWidth      = 128,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned PortW         = (NumPorts > 1) ? $clog2(NumPorts) : 1,
   localparam int unsigned MemIdW        = PortW + ClientIdWidth
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              stall_i,
   output logic                              busy_o,
   output logic                              err_o,
   input  logic [NumPorts-1:0]               cli_req_i,
   output logic [NumPorts-1:0]               cli_ack_o,
   input  logic [NumPorts*ClientIdWidth-1:0] cli_id_i,
   input  logic [NumPorts*ReqWidth-1:0]      cli_data_i,
   output logic [NumPorts-1:0]               cli_rtrn_vld_o,
   output logic [ClientIdWidth-1:0]          cli_rtrn_id_o,
   output logic [RtrnWidth-1:0]              cli_rtrn_o,
   output logic                              mem_req_o,
   input  logic                              mem_ack_i,
   output logic [MemIdW-1:0]                 mem_id_o,
   output logic [ReqWidth-1:0]               mem_data_o,
   input  logic                              mem_rtrn_vld_i,
   input  logic [MemIdW-1:0]                 mem_rtrn_id_i,
   input  logic [RtrnWidth-1:0]              mem_rtrn_i
);

   logic [3:0]               cnt_q [NumPorts];
   logic [PortW-1:0]         rr_q;
   logic [NumPorts-1:0]      eligible;
   logic                     slot_free;
   logic                     grant_vld;
   logic [PortW-1:0]         grant_idx;
   logic [ClientIdWidth-1:0] grant_id;
   logic [ReqWidth-1:0]      grant_data;
   logic [PortW-1:0]         rtrn_port;
   logic                     rtrn_drop;
   logic                     cnt_nonzero;

   assign slot_free = !mem_req_o || mem_ack_i;
   assign rtrn_port = mem_rtrn_id_i[MemIdW-1 -: PortW];

   // Grants are gated by rst_ni so the accept strobe is low the moment reset asserts.
   always_comb begin
      eligible    = '0;
      cnt_nonzero = 1'b0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         eligible[p] = rst_ni && cli_req_i[p] && !stall_i && (cnt_q[p] < 4'(MaxOutstanding));
         cnt_nonzero = cnt_nonzero || (cnt_q[p] != '0);
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise a path that skips
   // the assignment infers a latch.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      cli_ack_o  = '0;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_id   = '0;
      grant_data = '0;
      if (slot_free) begin
         for (int unsigned k = 0; k < NumPorts; k++) begin
            idx = (32'(rr_q) + k) % NumPorts;
            if (!grant_vld && eligible[idx]) begin
               grant_vld      = 1'b1;
               grant_idx      = PortW'(idx);
               grant_id       = cli_id_i[idx*ClientIdWidth +: ClientIdWidth];
               grant_data     = cli_data_i[idx*ReqWidth +: ReqWidth];
               cli_ack_o[idx] = 1'b1;
            end
         end
      end
   end

   // A same-cycle accept makes a return to an otherwise idle port legal.
   always_comb begin
      cli_rtrn_vld_o = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         cli_rtrn_vld_o[p] = rst_ni && mem_rtrn_vld_i && (rtrn_port == PortW'(p)) &&
                             ((cnt_q[p] != '0) || cli_ack_o[p]);
      end
   end

   assign rtrn_drop     = mem_rtrn_vld_i && !(|cli_rtrn_vld_o);
   assign cli_rtrn_id_o = mem_rtrn_id_i[ClientIdWidth-1:0];
   assign cli_rtrn_o    = mem_rtrn_i;
   assign busy_o        = mem_req_o || cnt_nonzero;

   // NOTE: the payload register is reset along with the valid bit so mem_id_o and
   // mem_data_o read as zero after reset rather than holding stale data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_req_o  <= 1'b0;
         mem_id_o   <= '0;
         mem_data_o <= '0;
         rr_q       <= '0;
         err_o      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         if (grant_vld) begin
            mem_req_o  <= 1'b1;
            mem_id_o   <= {grant_idx, grant_id};
            mem_data_o <= grant_data;
            rr_q       <= PortW'((32'(grant_idx) + 1) % NumPorts);
         end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
         end
         if (rtrn_drop) begin
            err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            cnt_q[p] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            case ({cli_ack_o[p], cli_rtrn_vld_o[p]})
               2'b10:   cnt_q[p] <= cnt_q[p] + 4'd1;
               2'b01:   cnt_q[p] <= cnt_q[p] - 4'd1;
               default: cnt_q[p] <= cnt_q[p];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Randomized bench for wt_mem_arbiter: a transaction-level model of clients, the
// output slot and per-port in-flight counts predicts every output each cycle.
module tb_wt_mem_arbiter;

   localparam int N    = 3;
   localparam int CIW  = 2;
   localparam int RW   = 32;
   localparam int TW   = 32;
   localparam int MAXO = 4;
   localparam int PW   = 2;
   localparam int MIW  = PW + CIW;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             stall_i = 1'b0;
   logic             busy_o, err_o;
   logic [N-1:0]     cli_req_i = '0;
   logic [N-1:0]     cli_ack_o;
   logic [N*CIW-1:0] cli_id_i = '0;
   logic [N*RW-1:0]  cli_data_i = '0;
   logic [N-1:0]     cli_rtrn_vld_o;
   logic [CIW-1:0]   cli_rtrn_id_o;
   logic [TW-1:0]    cli_rtrn_o;
   logic             mem_req_o;
   logic             mem_ack_i = 1'b0;
   logic [MIW-1:0]   mem_id_o;
   logic [RW-1:0]    mem_data_o;
   logic             mem_rtrn_vld_i = 1'b0;
   logic [MIW-1:0]   mem_rtrn_id_i = '0;
   logic [TW-1:0]    mem_rtrn_i = '0;

   always #5 clk_i = ~clk_i;

   wt_mem_arbiter #(
      .NumPorts(N), .ClientIdWidth(CIW), .ReqWidth(RW), .RtrnWidth(TW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .busy_o(busy_o), .err_o(err_o),
      .cli_req_i(cli_req_i), .cli_ack_o(cli_ack_o), .cli_id_i(cli_id_i), .cli_data_i(cli_data_i),
      .cli_rtrn_vld_o(cli_rtrn_vld_o), .cli_rtrn_id_o(cli_rtrn_id_o), .cli_rtrn_o(cli_rtrn_o),
      .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_id_o(mem_id_o), .mem_data_o(mem_data_o),
      .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_id_i(mem_rtrn_id_i), .mem_rtrn_i(mem_rtrn_i)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: in-flight count per port, next-priority port, output slot, error flag.
   int            m_cnt [N];
   int            m_rr;
   bit            m_req;
   int            m_id;
   logic [RW-1:0] m_data;
   bit            m_err;
   int            inflight[$];
   int            stale[$];

   // Client side: a request stays pending with a fixed id/payload until accepted.
   bit             pend  [N];
   logic [CIW-1:0] pid   [N];
   logic [RW-1:0]  pdata [N];

   task automatic model_reset();
      for (int p = 0; p < N; p++) m_cnt[p] = 0;
      m_rr = 0; m_req = 0; m_id = 0; m_data = '0; m_err = 0;
   endtask

   task automatic run_cycle(input int ack_pct, input int ret_pct, input int stall_pct,
                            input int req_pct, input int force_id);
      int g, rp, k, ret_id, exp_ack, exp_vld, busy;
      bit ret_v, drop;
      @(negedge clk_i);
      for (int p = 0; p < N; p++) begin
         if (!pend[p] && $urandom_range(99) < req_pct) begin
            pend[p]  = 1;
            pid[p]   = CIW'($urandom);
            pdata[p] = $urandom;
         end
         cli_req_i[p]            = pend[p];
         cli_id_i[p*CIW +: CIW]  = pid[p];
         cli_data_i[p*RW +: RW]  = pdata[p];
      end
      mem_ack_i = ($urandom_range(99) < ack_pct);
      stall_i   = ($urandom_range(99) < stall_pct);
      ret_v = 0; ret_id = 0;
      if (force_id >= 0) begin
         ret_v = 1; ret_id = force_id;
      end else if (inflight.size() > 0 && $urandom_range(99) < ret_pct) begin
         k = $urandom_range(inflight.size() - 1);
         ret_id = inflight[k];
         inflight.delete(k);
         ret_v = 1;
      end
      mem_rtrn_vld_i = ret_v;
      mem_rtrn_id_i  = MIW'(ret_id);
      mem_rtrn_i     = $urandom;
      #1;
      // Expected behaviour from the arbitration and routing rules.
      g = -1;
      if (!m_req || mem_ack_i) begin
         for (int j = 0; j < N; j++) begin
            int p;
            p = (m_rr + j) % N;
            if (g < 0 && pend[p] && m_cnt[p] < MAXO && !stall_i) g = p;
         end
      end
      exp_ack = (g >= 0) ? (1 << g) : 0;
      exp_vld = 0; drop = 0;
      rp = ret_id >> CIW;
      if (ret_v) begin
         if (rp < N && (m_cnt[rp] > 0 || g == rp)) exp_vld = 1 << rp;
         else drop = 1;
      end
      busy = m_req ? 1 : 0;
      for (int p = 0; p < N; p++) if (m_cnt[p] != 0) busy = 1;
      check("cli_ack", cli_ack_o, exp_ack);
      check("rtrn_vld", cli_rtrn_vld_o, exp_vld);
      if (exp_vld != 0) begin
         check("rtrn_id", cli_rtrn_id_o, ret_id % (1 << CIW));
         check("rtrn_data", cli_rtrn_o, mem_rtrn_i);
      end
      check("mem_req", mem_req_o, m_req);
      check("mem_id", mem_id_o, m_id);
      check("mem_data", mem_data_o, m_data);
      check("busy", busy_o, busy);
      check("err", err_o, m_err);
      // Advance the model across the coming rising edge.
      if (m_req && mem_ack_i) inflight.push_back(m_id);
      if (g >= 0) begin
         m_cnt[g]++;
         m_rr   = (g + 1) % N;
         m_req  = 1;
         m_id   = (g << CIW) | int'(pid[g]);
         m_data = pdata[g];
         pend[g] = 0;
      end else if (mem_ack_i) begin
         m_req = 0;
      end
      if (exp_vld != 0) m_cnt[rp]--;
      if (drop) m_err = 1;
   endtask

   task automatic quiet_inputs();
      cli_req_i = '0; stall_i = 0; mem_ack_i = 0; mem_rtrn_vld_i = 0;
   endtask

   initial begin
      for (int p = 0; p < N; p++) begin pend[p] = 0; pid[p] = '0; pdata[p] = '0; end
      model_reset();
      #12;
      check("rst_mem_req", mem_req_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_mem_id", mem_id_o, 0);
      @(negedge clk_i);
      rst_ni = 1;

      repeat (40)  run_cycle(100, 100, 0, 100, -1);   // full-rate alternation
      repeat (300) run_cycle(60, 40, 10, 60, -1);     // mixed random traffic
      repeat (30)  run_cycle(100, 0, 0, 100, -1);     // saturate in-flight limit
      repeat (20)  run_cycle(80, 30, 0, 100, -1);
      repeat (5)   run_cycle(0, 0, 0, 100, -1);       // memory back-pressure
      repeat (8)   run_cycle(100, 30, 100, 100, -1);  // stall
      run_cycle(50, 0, 100, 100, (3 << CIW) | 1);     // nonexistent port
      repeat (5)   run_cycle(60, 40, 0, 60, -1);

      // Reset in the middle of a burst with memory still owing returns.
      repeat (10)  run_cycle(100, 0, 0, 100, -1);
      @(negedge clk_i);
      cli_req_i = '1; stall_i = 0; mem_rtrn_vld_i = 1; mem_rtrn_id_i = MIW'(1 << CIW);
      #2;
      rst_ni = 0;
      #1;
      check("mid_rst_mem_req", mem_req_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_ack", cli_ack_o, 0);
      check("mid_rst_rtrn_vld", cli_rtrn_vld_o, 0);
      check("mid_rst_mem_id", mem_id_o, 0);
      check("mid_rst_mem_data", mem_data_o, 0);
      check("mid_rst_err", err_o, 0);
      model_reset();
      stale = inflight;
      inflight.delete();
      quiet_inputs();
      @(negedge clk_i);
      rst_ni = 1;
      check("stale_avail", stale.size() > 0, 1);
      if (stale.size() > 0) run_cycle(50, 0, 100, 100, stale[0]);
      repeat (200) run_cycle(60, 40, 10, 60, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wt_mem_arbiter.md
WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of cache clients (range 1..8).
REQ-002 SHALL have parameter ClientIdWidth, default 2, transaction-ID width per client.
REQ-003 SHALL have parameter ReqWidth, default 64, request payload width.
REQ-004 SHALL have parameter RtrnWidth, default 128, return payload width.
REQ-005 SHALL have parameter MaxOutstanding, default 4, per-port in-flight limit (range 1..15).
REQ-006 SHALL define PortW = max(1, clog2(NumPorts)) and MemIdW = PortW + ClientIdWidth.
REQ-007 clk_i  in  1  single clock, all state on rising edge.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 stall_i  in  1  blocks new grants while high.
REQ-010 busy_o  out  1  request pending or any transaction outstanding.
REQ-011 err_o  out  1  sticky protocol error flag.
REQ-012 cli_req_i  in  NumPorts  per-port request, held until acked.
REQ-013 cli_ack_o  out  NumPorts  per-port one-cycle accept.
REQ-014 cli_id_i  in  NumPorts x ClientIdWidth  per-port transaction ID.
REQ-015 cli_data_i  in  NumPorts x ReqWidth  per-port request payload.
REQ-016 cli_rtrn_vld_o  out  NumPorts  one-hot return valid.
REQ-017 cli_rtrn_id_o  out  ClientIdWidth  returned client ID (shared).
REQ-018 cli_rtrn_o  out  RtrnWidth  return payload (shared).
REQ-019 mem_req_o  out  1  memory request valid, held until mem_ack_i.
REQ-020 mem_ack_i  in  1  memory accepts request.
REQ-021 mem_id_o  out  MemIdW  {port index, client ID}.
REQ-022 mem_data_o  out  ReqWidth  registered payload.
REQ-023 mem_rtrn_vld_i  in  1  one return beat.
REQ-024 mem_rtrn_id_i  in  MemIdW  return ID.
REQ-025 mem_rtrn_i  in  RtrnWidth  return payload.

Function
REQ-026 SHALL hold a one-entry output register (valid, id, data); slot free when !mem_req_o or (mem_req_o & mem_ack_i).
REQ-027 Port p eligible SHALL = cli_req_i[p] & cnt[p] < MaxOutstanding & !stall_i.
REQ-028 When slot free and any eligible, SHALL grant exactly one port, round-robin starting at rr_ptr, asserting cli_ack_o[p] combinationally that cycle.
REQ-029 On grant SHALL load {p, cli_id_i[p]}, cli_data_i[p]; mem_req_o high next cycle (1-cycle latency); back-to-back grants on ack cycle allowed.
REQ-030 After grant to p SHALL set rr_ptr = (p+1) mod NumPorts; unchanged without grant.
REQ-031 mem_id_o/mem_data_o SHALL stay stable while mem_req_o & !mem_ack_i.
REQ-032 cnt[p] (4 bits) SHALL increment on cli_ack_o[p], decrement on routed return to p; both same cycle -> unchanged.
REQ-033 Return with mem_rtrn_vld_i SHALL route combinationally: cli_rtrn_vld_o[port field] = 1, cli_rtrn_id_o = low ClientIdWidth bits, cli_rtrn_o = mem_rtrn_i.
REQ-034 Return with port field >= NumPorts, or to port with cnt = 0 (and no same-cycle ack), SHALL be dropped (no valid, no count change) and set err_o.
REQ-035 err_o SHALL stay high until reset.
REQ-036 busy_o SHALL = mem_req_o | (any cnt != 0).
REQ-037 stall_i SHALL not affect an already-registered request or return routing.

Reset
REQ-038 On rst_ni low SHALL asynchronously clear: mem_req_o, mem_id_o, mem_data_o, all cnt, rr_ptr, err_o; combinational outputs therefore 0 (busy_o 0, cli_ack_o 0).
REQ-039 Reset mid-transaction SHALL discard register and counts; returns after reset for old IDs flag err_o.

Verification
REQ-040 NumPorts=2, both request every cycle, mem_ack_i=1 -> grants alternate 0,1,0,1, mem_req_o continuous after 1st cycle.
REQ-041 Port 0 issues 4 requests with no returns (MaxOutstanding=4) -> 5th not acked until return id {0,x} arrives; ack same or next cycle thereafter.
REQ-042 mem_ack_i held low 3 cycles -> mem_id_o/mem_data_o constant, no cli_ack_o.
REQ-043 Return id {1,2'b10} with cnt[1]=1 -> cli_rtrn_vld_o=2'b10, cli_rtrn_id_o=2, cnt[1]=0, busy_o drops if slot empty.
REQ-044 NumPorts=3, return port field 3 -> no valid output, err_o=1 sticky.
REQ-045 stall_i=1 with pending requests -> no acks; reset asserted mid-burst -> all outputs 0 immediately.
